// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core's decoded memory requests and a
// word-organised data memory. Stores are lane-replicated with byte enables;
// loads are lane-selected and sign/zero-extended into core_rd_o.
// FSM: IDLE -> ACCESS -> RESP -> IDLE.
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// H/HU/W requests raise lsu_fault_o. When it is undefined, the low address
// bits are masked and only an illegal size raises lsu_fault_o.
//
// Handshake: mem_req_o acts as a valid. Once raised it holds, and every mem_*
// output stays stable, until mem_ready_i is sampled high in an ACCESS cycle.
// The access completes on that edge. mem_ready_i is ignored in all other states.
module riscv_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_req_o,
  output logic              lsu_fault_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  input  logic              mem_ready_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [2:0]        size_q,     size_d;
  logic [1:0]        off_q,      off_d;
  logic              mem_req_q,  mem_req_d;
  logic              mem_we_q,   mem_we_d;
  logic [3:0]        mem_be_q,   mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wd_q,   mem_wd_d;
  logic [DATA_W-1:0] core_rd_q,  core_rd_d;

  logic              size_legal;
  logic              is_h;
  logic              is_w;
  logic              misaligned;
  logic              req_ok;
  logic [1:0]        req_off;
  logic [3:0]        req_be;
  logic [DATA_W-1:0] req_wd;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  // Decode the incoming request: legality, effective lane offset, enables, data.
  always_comb begin
    size_legal = (core_size_i == 3'd0) || (core_size_i == 3'd1) ||
                 (core_size_i == 3'd2) || (core_size_i == 3'd4) ||
                 (core_size_i == 3'd5);
    is_h = (core_size_i[1:0] == 2'd1);
    is_w = (core_size_i == 3'd2);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (is_h && core_addr_i[0]) || (is_w && (core_addr_i[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    req_ok = core_req_i && size_legal && !misaligned;
    // Masking the offset is a no-op for aligned requests and implements the
    // non-trapping behaviour for misaligned ones.
    if (is_w) begin
      req_off = 2'b00;
      req_be  = 4'b1111;
      req_wd  = core_wd_i;
    end else if (is_h) begin
      req_off = {core_addr_i[1], 1'b0};
      req_be  = 4'b0011 << req_off;
      req_wd  = {2{core_wd_i[15:0]}};
    end else begin
      req_off = core_addr_i[1:0];
      req_be  = 4'b0001 << req_off;
      req_wd  = {4{core_wd_i[7:0]}};
    end
  end

  // Select the addressed lane of the returned word and extend it per size.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rd_i[7:0];
      2'd1:    ld_byte = mem_rd_i[15:8];
      2'd2:    ld_byte = mem_rd_i[23:16];
      default: ld_byte = mem_rd_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q[1:0])
      2'd0:    ld_ext = {{24{!size_q[2] && ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{!size_q[2] && ld_half[15]}}, ld_half};
      default: ld_ext = mem_rd_i;
    endcase
  end

  // Next-state logic for the FSM and the registered memory-side outputs.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    core_rd_d  = core_rd_q;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          state_d    = S_ACCESS;
          size_d     = core_size_i;
          off_d      = req_off;
          mem_req_d  = 1'b1;
          mem_we_d   = core_we_i;
          mem_be_d   = req_be;
          mem_addr_d = {core_addr_i[ADDR_W-1:2], 2'b00};
          mem_wd_d   = req_wd;
        end
      end
      S_ACCESS: begin
        if (mem_ready_i) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          if (!mem_we_q) core_rd_d = ld_ext;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'd0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      core_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      core_rd_q  <= core_rd_d;
    end
  end

  // Stall covers the accepted request cycle and every ACCESS cycle.
  // A fault is flagged only for a rejected request seen in IDLE.
  always_comb begin
    core_stall_req_o = ((state_q == S_IDLE) && req_ok) || (state_q == S_ACCESS);
    lsu_fault_o      = (state_q == S_IDLE) && core_req_i && !req_ok;
  end

  assign core_rd_o  = core_rd_q;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_be_o   = mem_be_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;

endmodule
